i2c_target_responder: RTL and testbench

I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

---
 rtl/i2c_target_responder_if.sv | 30 +++
 rtl/i2c_target_responder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_responder_if.sv
// Application-side bus of the I2C target responder.
//   sample    : 16-bit value returned on reads (MSB byte first)
//   cmd       : first data byte of the last addressed write
//   cmd_valid : one-cycle pulse when cmd updates
//   rd_done   : one-cycle pulse when the initiator NACKs a read byte
//   busy      : target engaged in an addressed transaction
// The responder uses the slave modport; the application uses master.
interface i2c_target_responder_if;
  logic [15:0] sample;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic        rd_done;
  logic        busy;

  modport slave (
    input  sample,
    output cmd,
    output cmd_valid,
    output rd_done,
    output busy
  );

  modport master (
    output sample,
    input  cmd,
    input  cmd_valid,
    input  rd_done,
    input  busy
  );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target that ACKs its 7-bit address, captures the first written data
// byte as a command, and returns a latched 16-bit sample on reads.
// Oversampled: SCL/SDA are synchronized into mclk and all bus decisions are
// made on detected edges. No clock stretching.
//   mclk   : system clock (>= 10x SCL)
//   resetG : synchronous active-low reset
//   SCL    : I2C clock from the initiator (input only)
//   SDA    : I2C data, open-drain (pulled low when sda_oe=1, else high-Z)
//   app    : application bus (sample/cmd/cmd_valid/rd_done/busy)
module i2c_target_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h40,
  parameter int unsigned SYNC_STAGES = 2        // legal range 2..3
) (
  input  logic                         mclk,
  input  logic                         resetG,
  input  logic                         SCL,
  inout  wire                          SDA,
  i2c_target_responder_if.slave        app
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SMP_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

  // Synchronizers plus history flop
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;

  // Registered state and outputs
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-2:0]  shift, shift_nxt;
  logic [SMP_W-1:0]   shadow, shadow_nxt;
  logic               byte_idx, byte_idx_nxt;
  logic               rw, rw_nxt;
  logic               ack_hold, ack_hold_nxt;
  logic               first_wr, first_wr_nxt;
  logic               sda_oe, sda_oe_nxt;
  logic               busy_q, busy_nxt;
  logic [BYTE_W-1:0]  cmd_q, cmd_nxt;
  logic               cmd_valid_q, cmd_valid_nxt;
  logic               rd_done_q, rd_done_nxt;

  // Derived bus events
  logic              scl_rise, scl_fall, start_det, stop_det;
  logic [BYTE_W-1:0] rx_byte;
  logic [BYTE_W-1:0] rd_byte;
  logic [2:0]        bit_sel;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

  assign rx_byte = {shift, sda_s};
  assign rd_byte = byte_idx ? shadow[7:0] : shadow[15:8];
  assign bit_sel = 3'(3'd7 - bit_cnt[2:0]);

  // Open-drain pad
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  assign app.cmd       = cmd_q;
  assign app.cmd_valid = cmd_valid_q;
  assign app.rd_done   = rd_done_q;
  assign app.busy      = busy_q;

  // Input synchronizers; reset to the idle-bus level
  always_ff @(posedge mclk) begin
    if (!resetG) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // State and output registers
  always_ff @(posedge mclk) begin
    if (!resetG) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      shadow      <= '0;
      byte_idx    <= 1'b0;
      rw          <= 1'b0;
      ack_hold    <= 1'b0;
      first_wr    <= 1'b0;
      sda_oe      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift       <= shift_nxt;
      shadow      <= shadow_nxt;
      byte_idx    <= byte_idx_nxt;
      rw          <= rw_nxt;
      ack_hold    <= ack_hold_nxt;
      first_wr    <= first_wr_nxt;
      sda_oe      <= sda_oe_nxt;
      busy_q      <= busy_nxt;
      cmd_q       <= cmd_nxt;
      cmd_valid_q <= cmd_valid_nxt;
      rd_done_q   <= rd_done_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    shadow_nxt    = shadow;
    byte_idx_nxt  = byte_idx;
    rw_nxt        = rw;
    ack_hold_nxt  = ack_hold;
    first_wr_nxt  = first_wr;
    sda_oe_nxt    = sda_oe;
    busy_nxt      = busy_q;
    cmd_nxt       = cmd_q;
    cmd_valid_nxt = 1'b0;
    rd_done_nxt   = 1'b0;

    if (stop_det) begin
      // STOP is the only event allowed to move SDA while SCL is high
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (start_det) begin
      // START outranks any SCL edge seen in the same cycle
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte[BYTE_W-2:0];
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt_nxt = '0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_nxt    = ADDR_ACK;
                busy_nxt     = 1'b1;
                rw_nxt       = rx_byte[0];
                first_wr_nxt = ~rx_byte[0];
                ack_hold_nxt = 1'b0;
              end else begin
                state_nxt = IGNORE;
                busy_nxt  = 1'b0;
              end
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_hold) begin
              sda_oe_nxt   = 1'b1;
              ack_hold_nxt = 1'b1;
            end else if (rw) begin
              // ACK ends on the same fall that presents the first read bit
              state_nxt    = RD_BYTE;
              shadow_nxt   = app.sample;
              byte_idx_nxt = 1'b0;
              sda_oe_nxt   = ~app.sample[SMP_W-1];
              bit_cnt_nxt  = CNT_W'(1);
            end else begin
              state_nxt   = WR_BYTE;
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte[BYTE_W-2:0];
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
              bit_cnt_nxt  = '0;
              state_nxt    = WR_ACK;
              ack_hold_nxt = 1'b0;
              if (first_wr) begin
                cmd_nxt       = rx_byte;
                cmd_valid_nxt = 1'b1;
                first_wr_nxt  = 1'b0;
              end
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!ack_hold) begin
              sda_oe_nxt   = 1'b1;
              ack_hold_nxt = 1'b1;
            end else begin
              state_nxt   = WR_BYTE;
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
            end
          end
        end

        RD_BYTE: begin
          // bit_cnt counts bits already presented on SDA
          if (scl_fall) begin
            if (bit_cnt == CNT_W'(8)) begin
              state_nxt   = RD_ACK;
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
            end else begin
              sda_oe_nxt  = ~rd_byte[bit_sel];
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              state_nxt    = RD_BYTE;
              byte_idx_nxt = ~byte_idx;
              bit_cnt_nxt  = '0;
            end else begin
              state_nxt   = IGNORE;
              rd_done_nxt = 1'b1;
            end
          end
        end

        IDLE, IGNORE: begin
          sda_oe_nxt = 1'b0;
        end

        default: begin
          state_nxt  = IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: a bit-banged I2C initiator drives
// SCL/SDA with quarter-period timing; results are checked against
// hand-computed constants.
module tb_i2c_target_responder;

  localparam int Q = 100;   // quarter SCL period, 10 mclk cycles

  logic mclk = 1'b0;
  logic resetG = 1'b0;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda_line;

  pullup (sda_line);
  assign sda_line = m_sda_low ? 1'b0 : 1'bz;

  i2c_target_responder_if app_if ();

  i2c_target_responder #(
    .DEV_ADDR    (7'h40),
    .SYNC_STAGES (2)
  ) dut (
    .mclk   (mclk),
    .resetG (resetG),
    .SCL    (scl),
    .SDA    (sda_line),
    .app    (app_if)
  );

  always #5 mclk = ~mclk;

  int tests = 0;
  int fails = 0;

  // Event monitors
  int   cv_cnt = 0;
  int   rd_cnt = 0;
  int   oe_hi_cnt = 0;
  int   viol_cnt = 0;
  logic oe_q = 1'b0;

  always @(posedge mclk) begin
    if (app_if.cmd_valid) cv_cnt <= cv_cnt + 1;
    if (app_if.rd_done)   rd_cnt <= rd_cnt + 1;
    if (dut.sda_oe)       oe_hi_cnt <= oe_hi_cnt + 1;
    if (resetG && scl && (dut.sda_oe !== oe_q)) viol_cnt <= viol_cnt + 1;
    oe_q <= dut.sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; #(Q);
    scl = 1'b1;       #(Q);
    m_sda_low = 1'b1; #(Q);
    scl = 1'b0;       #(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; #(Q);
    scl = 1'b1;       #(Q);
    m_sda_low = 1'b0; #(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; #(Q);
    scl = 1'b1;     #(2*Q);
    scl = 1'b0;     #(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; #(Q);
    scl = 1'b1;       #(Q);
    b = sda_line;     #(Q);
    scl = 1'b0;       #(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic       b;
    int         cv0, rd0, oe0;

    app_if.sample = 16'h0000;

    // Reset state
    #(50);
    check("rst_cmd",       32'(app_if.cmd),       32'h00);
    check("rst_cmd_valid", 32'(app_if.cmd_valid), 32'h0);
    check("rst_rd_done",   32'(app_if.rd_done),   32'h0);
    check("rst_busy",      32'(app_if.busy),      32'h0);
    check("rst_sda_oe",    32'(dut.sda_oe),       32'h0);
    resetG = 1'b1;
    #(2*Q);

    // Write 0x80, 0xE3
    cv0 = cv_cnt;
    bus_start();
    write_byte(8'h80, ack);
    check("wr_addr_ack", 32'(ack), 32'h1);
    check("wr_busy", 32'(app_if.busy), 32'h1);
    write_byte(8'hE3, ack);
    check("wr_data_ack", 32'(ack), 32'h1);
    check("wr_cmd", 32'(app_if.cmd), 32'hE3);
    bus_stop();
    #(Q);
    check("wr_cv_pulses", 32'(cv_cnt - cv0), 32'h1);
    check("wr_busy_after_stop", 32'(app_if.busy), 32'h0);

    // Read 0x81 with sample 6A5C, ACK then NACK
    app_if.sample = 16'h6A5C;
    rd0 = rd_cnt;
    bus_start();
    write_byte(8'h81, ack);
    check("rd_addr_ack", 32'(ack), 32'h1);
    read_byte(d, 1'b1);
    check("rd_byte0", 32'(d), 32'h6A);
    read_byte(d, 1'b0);
    check("rd_byte1", 32'(d), 32'h5C);
    #(Q);
    check("rd_released", 32'(dut.sda_oe), 32'h0);
    check("rd_done_pulses", 32'(rd_cnt - rd0), 32'h1);
    bus_stop();
    #(Q);
    check("rd_busy_after_stop", 32'(app_if.busy), 32'h0);

    // Sample changes after address ACK: shadow must hold
    app_if.sample = 16'h6A5C;
    bus_start();
    write_byte(8'h81, ack);
    app_if.sample = 16'h1234;
    check("sh_addr_ack", 32'(ack), 32'h1);
    read_byte(d, 1'b1);
    check("sh_byte0", 32'(d), 32'h6A);
    read_byte(d, 1'b0);
    check("sh_byte1", 32'(d), 32'h5C);
    bus_stop();
    #(Q);

    // Foreign address 0x48
    cv0 = cv_cnt;
    oe0 = oe_hi_cnt;
    bus_start();
    write_byte(8'h90, ack);
    check("na_addr_ack", 32'(ack), 32'h0);
    check("na_busy", 32'(app_if.busy), 32'h0);
    write_byte(8'h55, ack);
    check("na_data_ack", 32'(ack), 32'h0);
    bus_stop();
    #(Q);
    check("na_oe_cycles", 32'(oe_hi_cnt - oe0), 32'h0);
    check("na_cmd", 32'(app_if.cmd), 32'hE3);
    check("na_cv_pulses", 32'(cv_cnt - cv0), 32'h0);

    // Write 0xF5, repeated START, read three bytes with wrap
    app_if.sample = 16'hBEEF;
    cv0 = cv_cnt;
    bus_start();
    write_byte(8'h80, ack);
    check("rs_wr_addr_ack", 32'(ack), 32'h1);
    write_byte(8'hF5, ack);
    check("rs_wr_data_ack", 32'(ack), 32'h1);
    check("rs_cmd", 32'(app_if.cmd), 32'hF5);
    bus_start();
    write_byte(8'h81, ack);
    check("rs_rd_addr_ack", 32'(ack), 32'h1);
    read_byte(d, 1'b1);
    check("rs_byte0", 32'(d), 32'hBE);
    read_byte(d, 1'b1);
    check("rs_byte1", 32'(d), 32'hEF);
    read_byte(d, 1'b0);
    check("rs_byte2_wrap", 32'(d), 32'hBE);
    bus_stop();
    #(Q);
    check("rs_cv_pulses", 32'(cv_cnt - cv0), 32'h1);

    // Reset while driving a 0 read bit
    app_if.sample = 16'h0000;
    bus_start();
    write_byte(8'h81, ack);
    check("rr_addr_ack", 32'(ack), 32'h1);
    check("rr_driving_oe", 32'(dut.sda_oe), 32'h1);
    check("rr_driving_line", 32'(sda_line), 32'h0);
    resetG = 1'b0;
    #(10);
    check("rr_oe_after_rst", 32'(dut.sda_oe), 32'h0);
    check("rr_line_after_rst", 32'(sda_line), 32'h1);
    resetG = 1'b1;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    check("rr_no_response", 32'(d), 32'hFF);
    check("rr_busy", 32'(app_if.busy), 32'h0);
    write_bit(1'b1);
    bus_stop();
    #(Q);
    bus_start();
    write_byte(8'h80, ack);
    check("rr_recover_ack", 32'(ack), 32'h1);
    bus_stop();
    #(Q);

    check("oe_change_scl_high", 32'(viol_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(2000000);
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
